instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Program-flow controller sitting between the instruction ROM and the MiniALU decode/execute stage. It owns the program counter, drives the ROM address, registers the fetched 28-bit instruction for decode, and applies stalls, taken branches and jumps, and NOP-encoded delay waits. It is the only block that sequences the ROM; execute reports redirects and busy status back to it.

## Interface
Parameters:
- RESET_ADDR, 16'd0: PC value after reset.
- DELAY_WIDTH, 24: width of the NOP delay counter; equals the NOP literal width.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- iEnable  in  1  run control; low parks the sequencer in IDLE.
- iInstruction  in  28  ROM data for oAddress; combinational from the ROM.
- iStall  in  1  execute busy (e.g. multi-cycle MULT); freezes issue.
- iBranchTaken  in  1  single-cycle redirect pulse from execute (taken BLE or JMP).
- iBranchTarget  in  16  redirect address, valid with iBranchTaken.
- oAddress  out  16  current PC, drives the ROM.
- oInstruction  out  28  registered instruction to decode.
- oValid  out  1  oInstruction is a new instruction this cycle.
- oBusy  out  1  high while in DELAY.

## Operation
- Instruction fields: [27:20] opcode, [19:0] operands. For NOP, [23:0] is the delay literal. Opcode values come from the shared definitions header.
- States:
  - IDLE: oValid=0. Goes to ISSUE when iEnable=1.
  - ISSUE: one instruction issued per cycle.
  - DELAY: NOP wait.
- Priority each cycle: Reset > iBranchTaken > iStall > iEnable low > normal issue.
- ISSUE, normal issue:
  - oInstruction<=iInstruction, oValid<=1, PC<=PC+1.
  - If the issued opcode is NOP and its literal N≠0: counter<=N and go to DELAY.
  - If N=0: remain in ISSUE (plain NOP, no wait).
- ISSUE, iStall=1: PC, oInstruction and state hold; oValid<=0. No instruction is ever issued twice.
- iEnable=0 in ISSUE: go to IDLE, oValid<=0, PC retained. Re-enable resumes at the retained PC.
- DELAY:
  - oValid=0, oBusy=1.
  - The counter decrements every cycle; iStall and iEnable are ignored.
  - When the counter reaches 1, return to ISSUE; the next instruction issues on the following cycle.
  - Exactly N non-valid cycles follow the NOP's valid cycle.
- iBranchTaken, in ISSUE or DELAY:
  - PC<=iBranchTarget, oValid<=0 (one-bubble flush), counter cleared, state<=ISSUE.
  - The instruction at the target issues on the next cycle.
  - Ignored in IDLE.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000 without error.
- Counter is DELAY_WIDTH bits, unsigned, no wrap. Leaving DELAY at a count of 1 means it never decrements below 0.

## Timing
- Reset values: oAddress=RESET_ADDR, oInstruction=28'd0, oValid=0, oBusy=0, state=IDLE, counter=0.
- Fetch latency is one cycle: with oAddress=A at edge k, ROM[A] appears on oInstruction with oValid=1 after edge k+1.
- The first valid instruction appears two edges after iEnable rises from IDLE: one edge to enter ISSUE, one edge to register.
- Branch: iBranchTaken sampled at edge k → oAddress=target after k, bubble (oValid=0) after k, ROM[target] valid after k+1.
- iBranchTaken and iStall in the same cycle: the branch wins; stall does not hold the old PC.
- Reset in any state, including mid-DELAY or mid-stall, returns all reset values on the next edge.
- oBusy is a registered function of state; oAddress equals the PC register with no combinational path from inputs.

## Structure
- Shared definitions header: opcode constants (NOP, JMP, BLE, ...), field positions (OPCODE_MSB/LSB, LITERAL width), and the state encodings IDLE/ISSUE/DELAY.
- One natural sub-module, delay_counter: a loadable DELAY_WIDTH down-counter with load, clear and a `done` flag at count 1. The FSM and PC live in instruction_sequencer.

## Test plan
- Reset then iEnable=1 with ROM[0..3] distinct → oValid low for 1 cycle, then ROM[0], ROM[1], ROM[2], ROM[3] on consecutive cycles; oAddress 1,2,3,4.
- ROM[2]=NOP with literal 24'd3 → NOP valid, then exactly 3 cycles of oValid=0 with oBusy=1, then ROM[3] valid. Literal 0 → no gap.
- iBranchTaken with target 16'd2 while issuing address 9 → one bubble, then ROM[2]. Repeat during DELAY → delay aborted, oBusy=0 next cycle.
- iStall held 4 cycles mid-stream → oValid=0 and oAddress frozen. On release, the next sequential instruction issues once, with no duplicate and no skip.
- RESET_ADDR=16'hFFFE → issues FFFE, FFFF, then 0000.
- Reset asserted mid-DELAY, and separately iEnable dropped then raised → reset gives all outputs at reset values. Enable toggle resumes at the retained PC with no lost instruction.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction field layout,
// the MiniALU opcode map and the sequencer state encoding.
package instruction_sequencer_pkg;

  localparam int INSTR_W    = 28;
  localparam int ADDR_W     = 16;
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 20;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
  localparam int LITERAL_W  = 24;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 8'h00,
    OP_ADD  = 8'h01,
    OP_SUB  = 8'h02,
    OP_MULT = 8'h03,
    OP_LD   = 8'h04,
    OP_ST   = 8'h05,
    OP_BLE  = 8'h10,
    OP_JMP  = 8'h11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DELAY = 2'd2
  } seq_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [LITERAL_W-1:0] literal_of(input logic [INSTR_W-1:0] instr);
    return instr[LITERAL_W-1:0];
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// ROM / execute-side signals of the instruction sequencer. The sequencer uses
// the slave view; the ROM and execute stage (or a bench) use the master view.
interface instruction_sequencer_if;
  import instruction_sequencer_pkg::*;

  logic                iEnable;
  logic [INSTR_W-1:0]  iInstruction;
  logic                iStall;
  logic                iBranchTaken;
  logic [ADDR_W-1:0]   iBranchTarget;
  logic [ADDR_W-1:0]   oAddress;
  logic [INSTR_W-1:0]  oInstruction;
  logic                oValid;
  logic                oBusy;

  modport master (
    output iEnable, iInstruction, iStall, iBranchTaken, iBranchTarget,
    input  oAddress, oInstruction, oValid, oBusy
  );

  modport slave (
    input  iEnable, iInstruction, iStall, iBranchTaken, iBranchTarget,
    output oAddress, oInstruction, oValid, oBusy
  );

endinterface

// File: rtl/instruction_sequencer_delay_counter.sv
// Loadable down-counter for NOP waits. done_o flags the last wait cycle
// (count of 1) so the sequencer never lets the count drop below zero.
module instruction_sequencer_delay_counter #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             clear_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: next-state gets its hold value first so no path through this block infers a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/instruction_sequencer.sv
// Program-flow controller: owns the PC, registers ROM data for decode and
// applies branch redirects, execute stalls and NOP-encoded delay waits.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR  = 16'd0,
  parameter int                DELAY_WIDTH = 24
) (
  input logic                    Clock,
  input logic                    Reset,
  instruction_sequencer_if.slave bus
);

  seq_state_e             state_q, state_d;
  logic [ADDR_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]     instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   cnt_load, cnt_clear, cnt_dec, cnt_done;
  logic [DELAY_WIDTH-1:0] nop_literal;
  logic                   is_nop;

  assign nop_literal = DELAY_WIDTH'(literal_of(bus.iInstruction));
  assign is_nop      = (opcode_of(bus.iInstruction) == OP_NOP);

  instruction_sequencer_delay_counter #(
    .WIDTH(DELAY_WIDTH)
  ) u_delay_counter (
    .Clock       (Clock),
    .Reset       (Reset),
    .load_i      (cnt_load),
    .load_value_i(nop_literal),
    .clear_i     (cnt_clear),
    .dec_i       (cnt_dec),
    .done_o      (cnt_done)
  );

  // Branch beats stall beats enable; a branch always costs exactly one bubble.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.iEnable) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (bus.iBranchTaken) begin
          pc_d      = bus.iBranchTarget;
          cnt_clear = 1'b1;
        end else if (!bus.iStall) begin
          if (!bus.iEnable) begin
            state_d = ST_IDLE;
          end else begin
            instr_d = bus.iInstruction;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            if (is_nop && (nop_literal != '0)) begin
              cnt_load = 1'b1;
              state_d  = ST_DELAY;
            end
          end
        end
      end

      ST_DELAY: begin
        if (bus.iBranchTaken) begin
          pc_d      = bus.iBranchTarget;
          cnt_clear = 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          // Busy marks the N wait cycles that follow the NOP's own valid cycle.
          cnt_dec = 1'b1;
          busy_d  = 1'b1;
          if (cnt_done) begin
            state_d = ST_ISSUE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_ADDR;
      instr_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.oAddress     = pc_q;
  assign bus.oInstruction = instr_q;
  assign bus.oValid       = valid_q;
  assign bus.oBusy        = busy_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: stimulus pushes expected (instruction, next PC) pairs,
// negedge monitors pop and compare whenever a sequencer presents oValid.
module tb_instruction_sequencer;

  typedef struct packed {
    logic [27:0] instr;
    logic [15:0] addr;
  } exp_t;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_errors;

  logic [27:0] rom [16];
  exp_t        q_a[$];
  exp_t        q_b[$];

  instruction_sequencer_if ifa();
  instruction_sequencer_if ifb();

  instruction_sequencer #(
    .RESET_ADDR (16'h0000),
    .DELAY_WIDTH(24)
  ) u_dut_a (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (ifa)
  );

  instruction_sequencer #(
    .RESET_ADDR (16'hFFFE),
    .DELAY_WIDTH(24)
  ) u_dut_b (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (ifb)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always_comb begin
    if (ifa.oAddress < 16'd16) ifa.iInstruction = rom[ifa.oAddress[3:0]];
    else                       ifa.iInstruction = {8'h20, 4'h0, ifa.oAddress};
  end

  always_comb ifb.iInstruction = {8'h30, 4'h0, ifb.oAddress};

  function automatic logic [27:0] plain_word(input int a);
    return {8'h20, 4'h0, 16'(a)};
  endfunction

  function automatic logic [27:0] nop_word(input int n);
    return {8'h00, 24'(n)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic push_a(input int idx, input logic [15:0] next_addr);
    exp_t e;
    e.instr = rom[idx];
    e.addr  = next_addr;
    q_a.push_back(e);
  endtask

  task automatic push_b(input logic [27:0] instr, input logic [15:0] next_addr);
    exp_t e;
    e.instr = instr;
    e.addr  = next_addr;
    q_b.push_back(e);
  endtask

  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && ifa.oValid) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_extra_valid: got instr %0h at addr %0h, expected no issue", ifa.oInstruction, ifa.oAddress);
      end else begin
        e = q_a.pop_front();
        check("a_instr", 32'(ifa.oInstruction), 32'(e.instr));
        check("a_addr", 32'(ifa.oAddress), 32'(e.addr));
      end
    end
    if (!Reset && ifb.oValid) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_extra_valid: got instr %0h at addr %0h, expected no issue", ifb.oInstruction, ifb.oAddress);
      end else begin
        e = q_b.pop_front();
        check("b_instr", 32'(ifb.oInstruction), 32'(e.instr));
        check("b_addr", 32'(ifb.oAddress), 32'(e.addr));
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) rom[i] = plain_word(i);
    Reset              = 1'b1;
    ifa.iEnable        = 1'b0;
    ifa.iStall         = 1'b0;
    ifa.iBranchTaken   = 1'b0;
    ifa.iBranchTarget  = 16'h0000;
    ifb.iEnable        = 1'b0;
    ifb.iStall         = 1'b0;
    ifb.iBranchTaken   = 1'b0;
    ifb.iBranchTarget  = 16'h0000;

    // Reset state, then sequential issue with an enable toggle.
    tick();
    tick();
    check("a_reset_addr", 32'(ifa.oAddress), 32'h0000);
    check("a_reset_instr", 32'(ifa.oInstruction), 32'h0);
    check("a_reset_valid", 32'(ifa.oValid), 32'h0);
    check("a_reset_busy", 32'(ifa.oBusy), 32'h0);
    check("b_reset_addr", 32'(ifb.oAddress), 32'hFFFE);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) push_a(i, 16'(i + 1));
    ifa.iEnable = 1'b1;
    tick();
    check("a_first_bubble", 32'(ifa.oValid), 32'h0);
    repeat (4) tick();
    ifa.iEnable = 1'b0;
    tick();
    check("a_disable_valid", 32'(ifa.oValid), 32'h0);
    check("a_disable_addr", 32'(ifa.oAddress), 32'h4);
    tick();
    tick();
    check("a_idle_addr_kept", 32'(ifa.oAddress), 32'h4);
    push_a(4, 16'd5);
    push_a(5, 16'd6);
    ifa.iEnable = 1'b1;
    tick();
    check("a_reenable_bubble", 32'(ifa.oValid), 32'h0);
    tick();
    tick();
    ifa.iEnable = 1'b0;
    tick();
    check("a_q_empty_seq", 32'(q_a.size()), 32'h0);

    // Stall held for four cycles mid-stream.
    for (int i = 6; i < 9; i++) push_a(i, 16'(i + 1));
    ifa.iEnable = 1'b1;
    tick();
    tick();
    ifa.iStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("a_stall_valid", 32'(ifa.oValid), 32'h0);
      check("a_stall_addr", 32'(ifa.oAddress), 32'h7);
    end
    ifa.iStall = 1'b0;
    tick();
    tick();
    ifa.iEnable = 1'b0;
    tick();
    check("a_q_empty_stall", 32'(q_a.size()), 32'h0);

    // NOP with literal 3, then a NOP with literal 0.
    rom[2] = nop_word(3);
    rom[5] = nop_word(0);
    pulse_reset();
    for (int i = 0; i < 7; i++) push_a(i, 16'(i + 1));
    ifa.iEnable = 1'b1;
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_delay_valid", 32'(ifa.oValid), 32'h0);
      check("a_delay_busy", 32'(ifa.oBusy), 32'h1);
      check("a_delay_addr", 32'(ifa.oAddress), 32'h3);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check("a_post_delay_valid", 32'(ifa.oValid), 32'h1);
      check("a_post_delay_busy", 32'(ifa.oBusy), 32'h0);
    end
    ifa.iEnable = 1'b0;
    tick();
    check("a_q_empty_nop", 32'(q_a.size()), 32'h0);
    rom[2] = plain_word(2);
    rom[5] = plain_word(5);

    // Branch (with a simultaneous stall) while at address 9, then branch out of DELAY.
    rom[12] = nop_word(5);
    pulse_reset();
    for (int i = 0; i < 9; i++) push_a(i, 16'(i + 1));
    ifa.iEnable = 1'b1;
    tick();
    repeat (9) tick();
    check("a_pre_branch_addr", 32'(ifa.oAddress), 32'h9);
    push_a(2, 16'd3);
    ifa.iBranchTaken  = 1'b1;
    ifa.iBranchTarget = 16'd2;
    ifa.iStall        = 1'b1;
    tick();
    ifa.iBranchTaken = 1'b0;
    ifa.iStall       = 1'b0;
    check("a_branch_bubble", 32'(ifa.oValid), 32'h0);
    check("a_branch_addr", 32'(ifa.oAddress), 32'h2);
    tick();
    push_a(12, 16'd13);
    ifa.iBranchTaken  = 1'b1;
    ifa.iBranchTarget = 16'd12;
    tick();
    ifa.iBranchTaken = 1'b0;
    check("a_branch2_addr", 32'(ifa.oAddress), 32'hC);
    tick();
    tick();
    check("a_in_delay_busy", 32'(ifa.oBusy), 32'h1);
    push_a(7, 16'd8);
    push_a(8, 16'd9);
    ifa.iBranchTaken  = 1'b1;
    ifa.iBranchTarget = 16'd7;
    tick();
    ifa.iBranchTaken = 1'b0;
    check("a_abort_valid", 32'(ifa.oValid), 32'h0);
    check("a_abort_busy", 32'(ifa.oBusy), 32'h0);
    check("a_abort_addr", 32'(ifa.oAddress), 32'h7);
    tick();
    tick();
    check("a_after_abort_busy", 32'(ifa.oBusy), 32'h0);
    ifa.iEnable = 1'b0;
    tick();
    check("a_q_empty_branch", 32'(q_a.size()), 32'h0);
    rom[12] = plain_word(12);

    // Reset mid-DELAY; enable and stall must not disturb the wait.
    rom[0] = nop_word(100);
    pulse_reset();
    push_a(0, 16'd1);
    ifa.iEnable = 1'b1;
    tick();
    tick();
    ifa.iEnable = 1'b0;
    ifa.iStall  = 1'b1;
    tick();
    tick();
    check("a_delay_ignores_en", 32'(ifa.oBusy), 32'h1);
    check("a_delay_hold_addr", 32'(ifa.oAddress), 32'h1);
    Reset = 1'b1;
    tick();
    check("a_mid_delay_rst_addr", 32'(ifa.oAddress), 32'h0000);
    check("a_mid_delay_rst_instr", 32'(ifa.oInstruction), 32'h0);
    check("a_mid_delay_rst_valid", 32'(ifa.oValid), 32'h0);
    check("a_mid_delay_rst_busy", 32'(ifa.oBusy), 32'h0);
    Reset      = 1'b0;
    ifa.iStall = 1'b0;
    rom[0]     = plain_word(0);
    tick();
    check("a_q_empty_reset", 32'(q_a.size()), 32'h0);

    // PC wrap from 16'hFFFE.
    push_b({8'h30, 4'h0, 16'hFFFE}, 16'hFFFF);
    push_b({8'h30, 4'h0, 16'hFFFF}, 16'h0000);
    push_b({8'h30, 4'h0, 16'h0000}, 16'h0001);
    ifb.iEnable = 1'b1;
    tick();
    check("b_first_bubble", 32'(ifb.oValid), 32'h0);
    repeat (3) tick();
    ifb.iEnable = 1'b0;
    tick();
    check("b_q_empty_wrap", 32'(q_b.size()), 32'h0);
    check("a_q_empty_final", 32'(q_a.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
